fifo4_16: RTL and testbench
===========================

// Module: fifo4_16
// PURPOSE
//  4-entry x 16-bit synchronous FIFO with valid/ready handshakes on both sides.
//  Holds four storage words and a 2-bit read pointer. A Mux4Way16 instance
//  selects the head word (a..d = slot 0..3, sel = rd_ptr).
//  Decouples a 16-bit producer from a consumer that may stall.
// PARAMETERS
//  WIDTH        16   data width; fixed at 16 to match the Mux4Way16 read path
//  DEPTH        4    entry count; fixed at 4 (one entry per mux input)
//  AFULL_LEVEL  3    occupancy at which almost_full asserts (legal range 1..4)
// PORTS
//  clk          in   1    single clock; all state updates on rising edge
//  reset_n      in   1    synchronous reset, active-low
//  in_data      in   16   write data
//  in_valid     in   1    producer offers in_data
//  in_ready     out  1    FIFO accepts in_data this cycle
//  out_data     out  16   head entry (combinational through Mux4Way16)
//  out_valid    out  1    out_data holds a valid entry
//  out_ready    in   1    consumer takes out_data this cycle
//  almost_full  out  1    count >= AFULL_LEVEL
//  empty        out  1    count == 0
// BEHAVIOUR
//  - State: slot0..slot3 [15:0], wr_ptr [1:0], rd_ptr [1:0], count [2:0] (0..4).
//  - Reset (reset_n low at edge): wr_ptr=0, rd_ptr=0, count=0, all slots=0.
//    Outputs after reset: in_ready=1, out_valid=0, empty=1, almost_full=0,
//    out_data=0.
//  - Reset has priority over every other event. Mid-operation reset discards
//    all entries. No push or pop completes on a reset edge.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != 4). Combinational from state only, never from
//    in_valid or out_ready.
//  - out_valid = (count != 0); empty = ~out_valid. State-only.
//  - push: slot[wr_ptr] <= in_data; wr_ptr <= wr_ptr+1 (mod 4, 3->0 wrap).
//  - pop: rd_ptr <= rd_ptr+1 (mod 4). The slot keeps its stale contents.
//  - count: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
//  - Latency: a word pushed into an empty FIFO appears on out_data with
//    out_valid=1 in the cycle after the push edge. There is no same-cycle
//    fall-through.
//  - Full (count=4): in_ready=0, so no push even if a pop occurs that cycle.
//    The pop alone frees a slot and in_ready rises next cycle.
//  - Empty (count=0): out_valid=0, so out_ready is ignored.
//    out_data = slot[rd_ptr] (stale value, don't-care to the consumer).
//  - Simultaneous push&pop at count 1..3: both complete and count holds.
//  - Order is strict FIFO; no entry is dropped or duplicated across
//    pointer wrap.
//  - out_data and in_data paths carry no arithmetic; width stays 16 throughout.
// CONFIGURATION
//  FIFO4_16_LEVEL_EN defined:
//    adds output port level [2:0] = count (0..4), registered, reset 0.
//    Also adds output port overflow_err [0:0], sticky, reset 0. It is set the
//    cycle after any edge where out_ready=1 while out_valid=0 (pop attempted
//    when empty). It is cleared only by reset.
//  FIFO4_16_LEVEL_EN undefined:
//    neither port exists; out_ready while empty is silently ignored.
//    All other behaviour is identical.
// TESTING
//  1 Reset: hold reset_n=0 2 cycles with in_valid=1 ->
//    in_ready=1, out_valid=0, empty=1, out_data=16'h0000, nothing stored.
//  2 Fill/drain: push 16'h1111,16'h2222,16'h3333,16'h4444 with out_ready=0 ->
//    almost_full=1 after 3rd push, in_ready=0 after 4th.
//    Then out_ready=1 -> pops return 1111,2222,3333,4444 in order, then empty=1.
//  3 Wrap: 6 rounds of push 1/pop 1 (values 16'hA000+i) ->
//    each value emerges 1 cycle after its push; pointers wrap 3->0 cleanly.
//  4 Full+pop: at count=4 drive in_valid=1 (16'hBEEF) and out_ready=1 ->
//    head popped, BEEF not written, count=3.
//    BEEF accepted next cycle, count=4.
//  5 Steady push&pop at count=2 for 8 cycles ->
//    count stays 2, output sequence equals input sequence delayed by 2 words.
//  6 Mid-op reset: count=3, pulse reset_n=0 1 cycle ->
//    empty=1, in_ready=1 next cycle, and the next push/pop returns only new data.
//    With FIFO4_16_LEVEL_EN: level=0; and out_ready=1 while empty ->
//    overflow_err=1 next cycle and it stays 1.

Source files
------------

// File: rtl/fifo4_16.sv
// fifo4_16: 4-entry x 16-bit synchronous FIFO with valid/ready handshakes on both sides.
//   clk, reset_n (sync, active-low)
//   in_data[15:0], in_valid -> in_ready           producer side
//   out_data[15:0], out_valid <- out_ready        consumer side; head is read through mux4way16
//   almost_full (count >= AFULL_LEVEL), empty (count == 0)
//   FIFO4_16_LEVEL_EN: adds level[2:0] (occupancy) and sticky overflow_err (pop attempted while empty)
module mux4way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [1:0]  sel,
    output logic [15:0] out
);
    assign out = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

module fifo4_16 #(
    parameter int AFULL_LEVEL = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        almost_full,
    output logic        empty
`ifdef FIFO4_16_LEVEL_EN
    ,
    output logic [2:0]  level,
    output logic [0:0]  overflow_err
`endif
);
    logic [15:0] slot_q [4];
    logic [15:0] slot_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic        push, pop;

    assign in_ready    = count_q != 3'd4;
    assign out_valid   = count_q != 3'd0;
    assign empty       = ~out_valid;
    assign almost_full = count_q >= 3'(AFULL_LEVEL);
    assign push        = in_valid & in_ready;
    assign pop         = out_valid & out_ready;

    always_comb begin
        slot_d = slot_q;
        if (push) slot_d[wr_ptr_q] = in_data;
        wr_ptr_d = wr_ptr_q + 2'(push);
        rd_ptr_d = rd_ptr_q + 2'(pop);
        count_d  = (push && !pop) ? count_q + 3'd1 : (pop && !push) ? count_q - 3'd1 : count_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            slot_q   <= slot_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    mux4way16 u_mux (
        .a  (slot_q[0]),
        .b  (slot_q[1]),
        .c  (slot_q[2]),
        .d  (slot_q[3]),
        .sel(rd_ptr_q),
        .out(out_data)
    );

`ifdef FIFO4_16_LEVEL_EN
    logic err_q, err_d;
    // sticky: any cycle the consumer asks for data while nothing is held
    assign err_d        = err_q | (out_ready & ~out_valid);
    assign level        = count_q;
    assign overflow_err = err_q;

    always_ff @(posedge clk) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`endif
endmodule

// File: tb/tb_fifo4_16.sv
// tb_fifo4_16: scoreboard bench for fifo4_16; stimulus queues expected words, a monitor checks each pop.
module tb_fifo4_16;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        almost_full;
    logic        empty;
`ifdef FIFO4_16_LEVEL_EN
    logic [2:0]  level;
    logic [0:0]  overflow_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q [$];

    fifo4_16 dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .almost_full(almost_full),
        .empty      (empty)
`ifdef FIFO4_16_LEVEL_EN
        ,
        .level       (level),
        .overflow_err(overflow_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: a pop completes at the coming edge when out_valid & out_ready
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_pop: got %h expected none at %0t", out_data, $time);
            end else begin
                chk("pop_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic push_word(input logic [15:0] v);
        in_data  = v;
        in_valid = 1'b1;
        exp_q.push_back(v);
        step();
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        repeat (n) step();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] fill [4];
        fill[0] = 16'h1111; fill[1] = 16'h2222; fill[2] = 16'h3333; fill[3] = 16'h4444;
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'hDEAD;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_empty", 16'(empty), 16'd1);
        chk("rst_almost_full", 16'(almost_full), 16'd0);
        chk("rst_out_data", out_data, 16'h0000);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        step();
        chk("rst_nothing_stored", 16'(empty), 16'd1);

        for (int i = 0; i < 4; i++) begin
            push_word(fill[i]);
            chk("fill_almost_full", 16'(almost_full), (i >= 2) ? 16'd1 : 16'd0);
            chk("fill_in_ready", 16'(in_ready), (i < 3) ? 16'd1 : 16'd0);
            chk("fill_empty", 16'(empty), 16'd0);
        end
        drain(4);
        chk("drain_empty", 16'(empty), 16'd1);
        chk("drain_out_valid", 16'(out_valid), 16'd0);

        for (int i = 0; i < 6; i++) begin
            push_word(16'hA000 + 16'(i));
            chk("wrap_latency_valid", 16'(out_valid), 16'd1);
            chk("wrap_latency_data", out_data, 16'hA000 + 16'(i));
            drain(1);
        end
        chk("wrap_empty", 16'(empty), 16'd1);

        for (int i = 1; i <= 4; i++) push_word(16'h5000 + 16'(i));
        chk("full_in_ready", 16'(in_ready), 16'd0);
        in_data   = 16'hBEEF;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("fullpop_in_ready", 16'(in_ready), 16'd1);
        chk("fullpop_almost_full", 16'(almost_full), 16'd1);
        push_word(16'hBEEF);
        chk("beef_full", 16'(in_ready), 16'd0);
        drain(4);
        chk("fullpop_empty", 16'(empty), 16'd1);

        push_word(16'hC000);
        push_word(16'hC001);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push_word(16'hC002 + 16'(i));
            chk("steady_almost_full", 16'(almost_full), 16'd0);
            chk("steady_out_valid", 16'(out_valid), 16'd1);
        end
        out_ready = 1'b0;
        chk("steady_head", out_data, 16'hC008);
        drain(2);
        chk("steady_empty", 16'(empty), 16'd1);

        for (int i = 1; i <= 3; i++) push_word(16'hD000 + 16'(i));
        chk("midrst_almost_full", 16'(almost_full), 16'd1);
        reset_n = 1'b0;
        exp_q.delete();
        step();
        reset_n = 1'b1;
        chk("midrst_empty", 16'(empty), 16'd1);
        chk("midrst_in_ready", 16'(in_ready), 16'd1);
`ifdef FIFO4_16_LEVEL_EN
        chk("midrst_level", 16'(level), 16'd0);
`endif
        push_word(16'hE001);
        chk("post_rst_head", out_data, 16'hE001);
        drain(1);
        chk("post_rst_empty", 16'(empty), 16'd1);
`ifdef FIFO4_16_LEVEL_EN
        chk("err_clear", 16'(overflow_err), 16'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("err_set", 16'(overflow_err), 16'd1);
        step();
        chk("err_sticky", 16'(overflow_err), 16'd1);
`endif
        step();
        chk("scoreboard_leftover", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
